// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter for the shared 64-bit memory port with tag ownership table
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      Icache2mem_command,
  input  logic [XLEN-1:0] Icache2mem_addr,
  input  logic [1:0]      Dcache2mem_command,
  input  logic [XLEN-1:0] Dcache2mem_addr,
  input  logic [63:0]     Dcache2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2Icache_response,
  output logic [63:0]     mem2Icache_data,
  output logic [3:0]      mem2Icache_tag,
  output logic [3:0]      mem2Dcache_response,
  output logic [63:0]     mem2Dcache_data,
  output logic [3:0]      mem2Dcache_tag
);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  // Table entry: valid bit plus owner (0 = icache, 1 = dcache)
  logic [NUM_TAGS-1:0] tag_valid;
  logic [NUM_TAGS-1:0] tag_owner;
  logic [3:0]          streak;

  logic i_req, d_req;
  logic grant_i, grant_d;
  logic alloc, retire, retire_owner;

  // Requests are masked while reset is held so every output reads idle immediately
  always_comb begin
    i_req   = !reset && (Icache2mem_command != CMD_NONE);
    d_req   = !reset && (Dcache2mem_command != CMD_NONE);
    grant_i = i_req && (!d_req || (streak == LIMIT));
    grant_d = d_req && !grant_i;
  end

  // Forward the granted request and steer the same-cycle accept tag back to the grantee
  always_comb begin
    proc2mem_command    = CMD_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = 64'd0;
    mem2Icache_response = 4'd0;
    mem2Dcache_response = 4'd0;
    if (grant_i) begin
      proc2mem_command    = Icache2mem_command;
      proc2mem_addr       = Icache2mem_addr;
      mem2Icache_response = mem2proc_response;
    end else if (grant_d) begin
      proc2mem_command    = Dcache2mem_command;
      proc2mem_addr       = Dcache2mem_addr;
      proc2mem_data       = Dcache2mem_data;
      mem2Dcache_response = mem2proc_response;
    end
  end

  // Completion lookup reads the pre-update owner, so a same-cycle reallocation cannot steal it
  always_comb begin
    retire         = !reset && (mem2proc_tag != 4'd0) && tag_valid[mem2proc_tag];
    retire_owner   = tag_owner[mem2proc_tag];
    alloc          = (mem2proc_response != 4'd0) &&
                     ((grant_i && (Icache2mem_command == CMD_LOAD)) ||
                      (grant_d && (Dcache2mem_command == CMD_LOAD)));
    mem2Icache_tag  = (retire && !retire_owner) ? mem2proc_tag : 4'd0;
    mem2Dcache_tag  = (retire &&  retire_owner) ? mem2proc_tag : 4'd0;
    mem2Icache_data = mem2proc_data;
    mem2Dcache_data = mem2proc_data;
  end

  // Count dcache wins over a waiting icache; any icache win or icache idle cycle resets it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak <= 4'd0;
    end else if (!i_req || grant_i) begin
      streak <= 4'd0;
    end else if (grant_d && (streak != LIMIT)) begin
      streak <= streak + 4'd1;
    end
  end

  // Valid bits: retire clears, allocate sets; allocate is written last so it wins on a tag clash
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
    end else begin
      if (retire) tag_valid[mem2proc_tag] <= 1'b0;
      if (alloc)  tag_valid[mem2proc_response] <= 1'b1;
    end
  end

  // Owner bits only matter while valid, so they carry no reset
  always_ff @(posedge clock) begin
    if (alloc) tag_owner[mem2proc_response] <= grant_d;
  end

`ifdef SIM
  logic [7:0] outstanding_i, outstanding_d;

  // Loads in flight per requester, for debug visibility
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding_i <= 8'd0;
      outstanding_d <= 8'd0;
    end else begin
      outstanding_i <= outstanding_i + 8'(alloc && grant_i) - 8'(retire && !retire_owner);
      outstanding_d <= outstanding_d + 8'(alloc && grant_d) - 8'(retire &&  retire_owner);
    end
  end

  // Memory must not hand out a tag that is still live, unless it completes this same cycle
  always_ff @(posedge clock) begin
    if (!reset && alloc && tag_valid[mem2proc_response] &&
        !(retire && (mem2proc_tag == mem2proc_response)))
      assert (1'b0) else $error("mem_arbiter: tag %0d reallocated while outstanding", mem2proc_response);
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter against a table-level reference model
module tb_mem_arbiter;
  localparam int XLEN = 32;
  localparam int NT   = 16;
  localparam int SL   = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      Icache2mem_command, Dcache2mem_command, proc2mem_command;
  logic [XLEN-1:0] Icache2mem_addr, Dcache2mem_addr, proc2mem_addr;
  logic [63:0]     Dcache2mem_data, mem2proc_data, proc2mem_data;
  logic [3:0]      mem2proc_response, mem2proc_tag;
  logic [3:0]      mem2Icache_response, mem2Icache_tag, mem2Dcache_response, mem2Dcache_tag;
  logic [63:0]     mem2Icache_data, mem2Dcache_data;

  mem_arbiter #(.XLEN(XLEN), .NUM_TAGS(NT), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .Icache2mem_command(Icache2mem_command), .Icache2mem_addr(Icache2mem_addr),
    .Dcache2mem_command(Dcache2mem_command), .Dcache2mem_addr(Dcache2mem_addr),
    .Dcache2mem_data(Dcache2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2Icache_response(mem2Icache_response), .mem2Icache_data(mem2Icache_data),
    .mem2Icache_tag(mem2Icache_tag),
    .mem2Dcache_response(mem2Dcache_response), .mem2Dcache_data(mem2Dcache_data),
    .mem2Dcache_tag(mem2Dcache_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]      cmd;
    logic [XLEN-1:0] addr;
    logic [63:0]     data;
    logic [3:0]      ri, rd, ti, td;
    logic [63:0]     cdata;
  } exp_t;

  exp_t q[$];
  bit   m_valid[NT];
  bit   m_owner[NT];
  int   m_wins;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", n, act, req);
  endtask

  // 0 = nobody, 1 = icache, 2 = dcache
  function automatic int pick_grant(input logic [1:0] ic, input logic [1:0] dc);
    if (ic != 0 && dc != 0) return (m_wins >= SL) ? 1 : 2;
    if (ic != 0) return 1;
    if (dc != 0) return 2;
    return 0;
  endfunction

  // resp < 0 / ctag < 0 request a randomly chosen legal memory behaviour
  task automatic cycle(input logic [1:0] ic, input logic [XLEN-1:0] ia,
                       input logic [1:0] dc, input logic [XLEN-1:0] da, input logic [63:0] dd,
                       input int resp, input int ctag, input logic [63:0] cd);
    int   g, r, t;
    int   freel[$];
    bit   hit;
    exp_t e;
    @(posedge clock); #1;
    g = pick_grant(ic, dc);
    t = ctag;
    if (t < 0) t = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(NT-1, 1));
    r = resp;
    if (r < 0) begin
      if (g == 0) r = int'($urandom_range(15));
      else begin
        for (int k = 1; k < NT; k++) if (!m_valid[k] && k != t) freel.push_back(k);
        if (freel.size() == 0 || $urandom_range(3) == 0) r = 0;
        else r = freel[$urandom_range(freel.size()-1)];
      end
    end
    Icache2mem_command = ic; Icache2mem_addr = ia;
    Dcache2mem_command = dc; Dcache2mem_addr = da; Dcache2mem_data = dd;
    mem2proc_response = 4'(r); mem2proc_tag = 4'(t); mem2proc_data = cd;
    e.cmd   = (g == 1) ? ic : (g == 2) ? dc : 2'd0;
    e.addr  = (g == 1) ? ia : (g == 2) ? da : '0;
    e.data  = (g == 2) ? dd : 64'd0;
    e.ri    = (g == 1) ? 4'(r) : 4'd0;
    e.rd    = (g == 2) ? 4'(r) : 4'd0;
    hit     = (t != 0) && m_valid[t];
    e.ti    = (hit && !m_owner[t]) ? 4'(t) : 4'd0;
    e.td    = (hit &&  m_owner[t]) ? 4'(t) : 4'd0;
    e.cdata = cd;
    q.push_back(e);
    if (ic == 0 || g == 1) m_wins = 0;
    else if (g == 2 && m_wins < SL) m_wins++;
    if (hit) m_valid[t] = 0;
    if (r != 0 && ((g == 1 && ic == 2'd1) || (g == 2 && dc == 2'd1))) begin
      m_valid[r] = 1;
      m_owner[r] = (g == 2);
    end
  endtask

  task automatic idle(input int ctag);
    cycle(2'd0, '0, 2'd0, '0, 64'd0, 0, ctag, 64'd0);
  endtask

  task automatic chk_idle(input string n);
    chk({n, "_cmd"}, 64'(proc2mem_command), 64'd0);
    chk({n, "_addr"}, 64'(proc2mem_addr), 64'd0);
    chk({n, "_data"}, proc2mem_data, 64'd0);
    chk({n, "_iresp"}, 64'(mem2Icache_response), 64'd0);
    chk({n, "_dresp"}, 64'(mem2Dcache_response), 64'd0);
    chk({n, "_itag"}, 64'(mem2Icache_tag), 64'd0);
    chk({n, "_dtag"}, 64'(mem2Dcache_tag), 64'd0);
  endtask

  // Monitor: compare every presented cycle against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cmd", 64'(proc2mem_command), 64'(e.cmd));
        chk("addr", 64'(proc2mem_addr), 64'(e.addr));
        chk("pdata", proc2mem_data, e.data);
        chk("iresp", 64'(mem2Icache_response), 64'(e.ri));
        chk("dresp", 64'(mem2Dcache_response), 64'(e.rd));
        chk("itag", 64'(mem2Icache_tag), 64'(e.ti));
        chk("dtag", 64'(mem2Dcache_tag), 64'(e.td));
        chk("idata", mem2Icache_data, e.cdata);
        chk("ddata", mem2Dcache_data, e.cdata);
      end
    end
  end

  initial begin
    string pat;
    m_wins = 0;
    // Reset state, with live-looking inputs that must be masked
    Icache2mem_command = 2'd1; Icache2mem_addr = 32'h40;
    Dcache2mem_command = 2'd2; Dcache2mem_addr = 32'h80; Dcache2mem_data = 64'h1234;
    mem2proc_response = 4'd3; mem2proc_tag = 4'd3; mem2proc_data = 64'd0;
    #2;
    chk_idle("reset");
    Icache2mem_command = 2'd0; Dcache2mem_command = 2'd0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Idle
    repeat (10) idle(0);
    // Icache alone, then completion
    cycle(2'd1, 32'h100, 2'd0, '0, 64'd0, 3, 0, 64'd0);
    idle(0);
    cycle(2'd0, '0, 2'd0, '0, 64'd0, 0, 3, 64'hDEADBEEF_CAFEF00D);
    idle(3);
    // Store never allocates
    cycle(2'd0, '0, 2'd2, 32'h200, 64'h55, 5, 0, 64'd0);
    idle(5);
    // Same-cycle retire/allocate of tag 7
    cycle(2'd1, 32'h108, 2'd0, '0, 64'd0, 7, 0, 64'd0);
    cycle(2'd0, '0, 2'd1, 32'h300, 64'd0, 7, 7, 64'h77);
    idle(7);
    // Contention: fixed grant pattern
    pat = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      cycle(2'd1, 32'h1000 + 32'(k*8), 2'd1, 32'h2000 + 32'(k*8), 64'd0, k+1, 0, 64'd0);
      #1;
      chk("grant_seq", 64'(proc2mem_addr),
          (pat[k] == "I") ? 64'h1000 + 64'(k*8) : 64'h2000 + 64'(k*8));
    end
    for (int k = 1; k <= 10; k++) idle(k);
    // Randomized traffic
    for (int k = 0; k < 400; k++)
      cycle(2'($urandom_range(1)), $urandom, 2'($urandom_range(2)), $urandom,
            {$urandom, $urandom}, -1, -1, {$urandom, $urandom});
    for (int k = 1; k < NT; k++) idle(k);
    // Reset mid-flight
    cycle(2'd1, 32'h500, 2'd0, '0, 64'd0, 2, 0, 64'd0);
    cycle(2'd0, '0, 2'd1, 32'h600, 64'd0, 9, 0, 64'd0);
    @(negedge clock); #2;
    reset = 1'b1;
    Icache2mem_command = 2'd1; Dcache2mem_command = 2'd1;
    mem2proc_response = 4'd4; mem2proc_tag = 4'd2;
    #1;
    chk_idle("midreset");
    Icache2mem_command = 2'd0; Dcache2mem_command = 2'd0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < NT; k++) m_valid[k] = 0;
    m_wins = 0;
    idle(2);
    idle(9);
    repeat (2) @(negedge clock);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
